// File: rtl/point_packet_scheduler.sv
// point_packet_scheduler
// Sends the four centroids of the multi-point finder to the host link once per
// (decimated) camera frame. The end of a frame is taken from the falling edge of
// VGA_VS. At that point the point inputs are snapshotted. The snapshot is then
// sent as a 20-byte packet:
//   SYNC0, SYNC1, frame, H0..V3 (big-endian), checksum
// The bytes go out over a valid/ready byte interface.
//
// Ports:
//   CLK, RESET_N             clock, asynchronous active-low reset
//   VGA_VS                   vertical sync, high during the active frame
//   SEND_EN                  level enable for starting packets
//   POINTS_H_0..3/V_0..3     live 16-bit point coordinates
//   TX_READY                 downstream accepts the presented byte
//   TX_DATA, TX_VALID        presented byte and its qualifier
//   BUSY                     packet in progress
//   FRAME_CNT                packets started (wraps)
//   DROP_CNT                 eligible frames lost while busy (saturates)
module point_packet_scheduler #(
    parameter int unsigned DECIMATE = 1,
    parameter logic [7:0]  SYNC0    = 8'hAA,
    parameter logic [7:0]  SYNC1    = 8'h55
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        VGA_VS,
    input  logic        SEND_EN,
    input  logic [15:0] POINTS_H_0,
    input  logic [15:0] POINTS_H_1,
    input  logic [15:0] POINTS_H_2,
    input  logic [15:0] POINTS_H_3,
    input  logic [15:0] POINTS_V_0,
    input  logic [15:0] POINTS_V_1,
    input  logic [15:0] POINTS_V_2,
    input  logic [15:0] POINTS_V_3,
    input  logic        TX_READY,
    output logic [7:0]  TX_DATA,
    output logic        TX_VALID,
    output logic        BUSY,
    output logic [7:0]  FRAME_CNT,
    output logic [7:0]  DROP_CNT
);

    localparam logic [4:0] LAST_IDX = 5'd19;

    typedef enum logic {IDLE, SEND} state_t;

    state_t      state, state_next;
    logic        vs_q;
    logic        fe;
    logic        eligible;
    logic        xfer;
    logic        start;
    logic        finish;
    logic [7:0]  dc;
    logic [4:0]  idx;
    logic [4:0]  next_idx;
    logic [3:0]  field;
    logic [7:0]  next_byte;
    logic [7:0]  csum;
    logic [7:0]  snap_frame;
    logic [15:0] snap_h [4];
    logic [15:0] snap_v [4];

    assign fe       = vs_q & ~VGA_VS;
    assign eligible = fe & SEND_EN & (dc == 8'd0);
    assign xfer     = TX_VALID & TX_READY;
    assign BUSY     = (state == SEND);

    // Next-state logic.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        state_next = state;
        start      = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: if (eligible) begin
                start      = 1'b1;
                state_next = SEND;
            end
            SEND: if (xfer && idx == LAST_IDX) begin
                finish     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Byte presented after the current one transfers. Bytes 3..18 walk the
    // snapshot point by point: H hi, H lo, V hi, V lo.
    assign next_idx = idx + 5'd1;
    assign field    = 4'(next_idx - 5'd3);

    always_comb begin
        next_byte = 8'h00;
        if (next_idx == 5'd1) begin
            next_byte = SYNC1;
        end else if (next_idx == 5'd2) begin
            next_byte = snap_frame;
        end else if (next_idx == LAST_IDX) begin
            next_byte = csum;
        end else if (next_idx >= 5'd3 && next_idx <= 5'd18) begin
            case (field[1:0])
                2'd0:    next_byte = snap_h[field[3:2]][15:8];
                2'd1:    next_byte = snap_h[field[3:2]][7:0];
                2'd2:    next_byte = snap_v[field[3:2]][15:8];
                default: next_byte = snap_v[field[3:2]][7:0];
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= IDLE;
            vs_q      <= 1'b0;
            dc        <= 8'd0;
            idx       <= 5'd0;
            csum      <= 8'd0;
            TX_DATA   <= 8'h00;
            TX_VALID  <= 1'b0;
            FRAME_CNT <= 8'd0;
            DROP_CNT  <= 8'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state <= state_next;
            vs_q  <= VGA_VS;

            if (!SEND_EN)
                dc <= 8'd0;
            else if (fe)
                dc <= (dc == 8'(DECIMATE - 1)) ? 8'd0 : dc + 8'd1;

            // An eligible frame that arrives while a packet is still open is
            // dropped. This includes the edge that transfers the last byte.
            if (eligible && state == SEND && DROP_CNT != 8'hFF)
                DROP_CNT <= DROP_CNT + 8'd1;

            if (start) begin
                FRAME_CNT <= FRAME_CNT + 8'd1;
                TX_DATA   <= SYNC0;
                TX_VALID  <= 1'b1;
                idx       <= 5'd0;
                csum      <= 8'd0;
            end else if (finish) begin
                TX_VALID <= 1'b0;
                idx      <= 5'd0;
            end else if (state == SEND && xfer) begin
                idx     <= next_idx;
                TX_DATA <= next_byte;
                // The checksum accumulates as bytes 2..18 are presented. It is
                // therefore complete by the time byte 19 is selected.
                if (next_idx >= 5'd2 && next_idx <= 5'd18)
                    csum <= csum + next_byte;
            end
        end
    end

    // The snapshot is only read after it has been loaded.
    always_ff @(posedge CLK) begin
        // NOTE: the snapshot registers are deliberately left out of reset; nothing reads them before a load.
        if (start) begin
            snap_frame <= FRAME_CNT;
            snap_h[0]  <= POINTS_H_0;
            snap_h[1]  <= POINTS_H_1;
            snap_h[2]  <= POINTS_H_2;
            snap_h[3]  <= POINTS_H_3;
            snap_v[0]  <= POINTS_V_0;
            snap_v[1]  <= POINTS_V_1;
            snap_v[2]  <= POINTS_V_2;
            snap_v[3]  <= POINTS_V_3;
        end
    end

endmodule

// File: tb/tb_point_packet_scheduler.sv
// Self-checking bench for point_packet_scheduler. It uses two instances:
// - dut1: DECIMATE=1, used for the main tests.
// - dut3: DECIMATE=3, used for the decimation test.
// Each instance has its own VS input. Expected packets are pushed into a
// per-instance queue when a frame end is driven. The queue is popped on every
// observed valid & ready transfer.
module tb_point_packet_scheduler;

    localparam logic [7:0] S0 = 8'hAA;
    localparam logic [7:0] S1 = 8'h55;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        vs1 = 1'b1;
    logic        vs3 = 1'b1;
    logic        SEND_EN = 1'b0;
    logic        TX_READY = 1'b1;
    logic [15:0] ph [4];
    logic [15:0] pv [4];

    logic [7:0]  d1_data, d3_data, d1_fc, d3_fc, d1_dc, d3_dc;
    logic        d1_valid, d3_valid, d1_busy, d3_busy;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [7:0]  sb1 [$];
    logic [7:0]  sb3 [$];
    bit          bp_mode = 1'b0;
    int          bp_k = 0;
    logic [3:0]  bp_pat = 4'b1001;

    always #5 CLK = ~CLK;

    point_packet_scheduler #(.DECIMATE(1)) dut1 (
        .CLK(CLK), .RESET_N(RESET_N), .VGA_VS(vs1), .SEND_EN(SEND_EN),
        .POINTS_H_0(ph[0]), .POINTS_H_1(ph[1]), .POINTS_H_2(ph[2]), .POINTS_H_3(ph[3]),
        .POINTS_V_0(pv[0]), .POINTS_V_1(pv[1]), .POINTS_V_2(pv[2]), .POINTS_V_3(pv[3]),
        .TX_READY(TX_READY), .TX_DATA(d1_data), .TX_VALID(d1_valid), .BUSY(d1_busy),
        .FRAME_CNT(d1_fc), .DROP_CNT(d1_dc)
    );

    point_packet_scheduler #(.DECIMATE(3)) dut3 (
        .CLK(CLK), .RESET_N(RESET_N), .VGA_VS(vs3), .SEND_EN(SEND_EN),
        .POINTS_H_0(ph[0]), .POINTS_H_1(ph[1]), .POINTS_H_2(ph[2]), .POINTS_H_3(ph[3]),
        .POINTS_V_0(pv[0]), .POINTS_V_1(pv[1]), .POINTS_V_2(pv[2]), .POINTS_V_3(pv[3]),
        .TX_READY(TX_READY), .TX_DATA(d3_data), .TX_VALID(d3_valid), .BUSY(d3_busy),
        .FRAME_CNT(d3_fc), .DROP_CNT(d3_dc)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Monitors: sample on the falling edge, between active edges.
    logic       stall1 = 1'b0, stall3 = 1'b0;
    logic [7:0] held1 = 8'h00, held3 = 8'h00;

    always @(negedge CLK) begin
        if (stall1 && RESET_N)
            check("d1_stall_hold", {d1_valid, d1_data}, {1'b1, held1});
        if (RESET_N && d1_valid && TX_READY) begin
            check("d1_byte_expected", sb1.size() != 0, 1);
            if (sb1.size() != 0)
                check("d1_byte", d1_data, sb1.pop_front());
        end
        stall1 = RESET_N && d1_valid && !TX_READY;
        held1  = d1_data;
    end

    always @(negedge CLK) begin
        if (stall3 && RESET_N)
            check("d3_stall_hold", {d3_valid, d3_data}, {1'b1, held3});
        if (RESET_N && d3_valid && TX_READY) begin
            check("d3_byte_expected", sb3.size() != 0, 1);
            if (sb3.size() != 0)
                check("d3_byte", d3_data, sb3.pop_front());
        end
        stall3 = RESET_N && d3_valid && !TX_READY;
        held3  = d3_data;
    end

    // One clock: inputs change 1 time unit after the rising edge.
    task automatic step();
        @(posedge CLK);
        #1;
        if (bp_mode) begin
            TX_READY = bp_pat[bp_k % 4];
            bp_k++;
        end
    endtask

    // Reference packet built from the current point inputs.
    task automatic push_pkt(input bit d3, input logic [7:0] frame);
        logic [7:0] b [20];
        logic [7:0] sum;
        b[0] = S0;
        b[1] = S1;
        b[2] = frame;
        for (int p = 0; p < 4; p++) begin
            b[3 + 4*p] = ph[p][15:8];
            b[4 + 4*p] = ph[p][7:0];
            b[5 + 4*p] = pv[p][15:8];
            b[6 + 4*p] = pv[p][7:0];
        end
        sum = 8'h00;
        for (int i = 2; i <= 18; i++) sum = sum + b[i];
        b[19] = sum;
        for (int i = 0; i < 20; i++) begin
            if (d3) sb3.push_back(b[i]);
            else    sb1.push_back(b[i]);
        end
    endtask

    task automatic wait_done(input bit d3, input int budget);
        int c = 0;
        while (c < budget && ((d3 ? sb3.size() : sb1.size()) != 0 || (d3 ? d3_busy : d1_busy))) begin
            step();
            c++;
        end
        check(d3 ? "d3_done_in_budget" : "d1_done_in_budget", c < budget, 1);
    endtask

    task automatic fall1();
        vs1 = 1'b0;
        step(); step();
        vs1 = 1'b1;
        step(); step();
    endtask

    task automatic do_reset();
        RESET_N  = 1'b0;
        vs1      = 1'b1;
        vs3      = 1'b1;
        TX_READY = 1'b1;
        bp_mode  = 1'b0;
        sb1.delete();
        sb3.delete();
        repeat (3) step();
        RESET_N = 1'b1;
        repeat (2) step();
    endtask

    task automatic set_points();
        for (int p = 0; p < 4; p++) begin
            ph[p] = {8'(4*p + 1), 8'(4*p + 2)};
            pv[p] = {8'(4*p + 3), 8'(4*p + 4)};
        end
    endtask

    initial begin
        set_points();
        #1;
        // Reset state
        check("rst_valid", d1_valid, 0);
        check("rst_data", d1_data, 0);
        check("rst_busy", d1_busy, 0);
        check("rst_frame_cnt", d1_fc, 0);
        check("rst_drop_cnt", d1_dc, 0);
        do_reset();
        SEND_EN = 1'b1;

        // Single packet with one-cycle start latency
        push_pkt(0, 8'h00);
        check("sb_last_is_0x88", sb1[19], 8'h88);
        vs1 = 1'b0;
        step();
        check("latency_valid", d1_valid, 1);
        check("latency_sync0", d1_data, S0);
        vs1 = 1'b1;
        wait_done(0, 100);
        check("single_frame_cnt", d1_fc, 1);
        check("single_busy", d1_busy, 0);
        check("single_valid_low", d1_valid, 0);

        // Backpressure with TX_READY pattern 1,0,0,1
        do_reset();
        bp_k    = 0;
        bp_mode = 1'b1;
        push_pkt(0, 8'h00);
        fall1();
        wait_done(0, 300);
        bp_mode  = 1'b0;
        TX_READY = 1'b1;
        check("bp_frame_cnt", d1_fc, 1);

        // Snapshot integrity: live inputs change mid-packet
        do_reset();
        push_pkt(0, 8'h00);
        vs1 = 1'b0;
        step();
        vs1 = 1'b1;
        step(); step();
        for (int p = 0; p < 4; p++) begin
            ph[p] = 16'hFFFF;
            pv[p] = 16'hFFFF;
        end
        wait_done(0, 100);
        set_points();

        // Drops while the link is held busy
        do_reset();
        TX_READY = 1'b0;
        push_pkt(0, 8'h00);
        fall1();
        check("drop_busy_held", d1_busy, 1);
        repeat (3) fall1();
        check("drop_cnt", d1_dc, 3);
        check("drop_frame_cnt", d1_fc, 1);
        TX_READY = 1'b1;
        wait_done(0, 100);
        repeat (40) step();
        check("drop_one_packet_only", d1_valid, 0);
        check("drop_frame_cnt_after", d1_fc, 1);
        check("drop_cnt_after", d1_dc, 3);

        // Decimation by 3 on dut3
        do_reset();
        for (int i = 0; i < 7; i++) begin
            if (i % 3 == 0) push_pkt(1, 8'(i / 3));
            vs3 = 1'b0;
            step(); step();
            vs3 = 1'b1;
            repeat (28) step();
        end
        wait_done(1, 100);
        check("decim_frame_cnt", d3_fc, 3);
        check("decim_drop_cnt", d3_dc, 0);
        SEND_EN = 1'b0;
        for (int i = 0; i < 7; i++) begin
            vs3 = 1'b0;
            step(); step();
            vs3 = 1'b1;
            repeat (28) step();
        end
        check("decim_disabled_frame_cnt", d3_fc, 3);
        check("decim_disabled_valid", d3_valid, 0);
        SEND_EN = 1'b1;

        // Reset while byte index 10 is presented
        do_reset();
        push_pkt(0, 8'h00);
        fall1();
        begin
            int c = 0;
            while (sb1.size() > 10 && c < 100) begin
                step();
                c++;
            end
            check("mid_reached_idx10", sb1.size(), 10);
        end
        RESET_N = 1'b0;
        #1;
        check("mid_rst_valid", d1_valid, 0);
        check("mid_rst_busy", d1_busy, 0);
        check("mid_rst_frame_cnt", d1_fc, 0);
        check("mid_rst_drop_cnt", d1_dc, 0);
        sb1.delete();
        repeat (3) step();
        RESET_N = 1'b1;
        repeat (30) step();
        check("mid_no_resume", d1_valid, 0);
        push_pkt(0, 8'h00);
        fall1();
        wait_done(0, 100);
        check("mid_after_frame_cnt", d1_fc, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/point_packet_scheduler.md
Name: point_packet_scheduler

Overview:
- Sequences the four centroid results of the multi-point finder out to the host link once per camera frame.
- Detects end of frame on VGA_VS and snapshots POINTS_H/V_0..3 so they cannot change mid-packet.
- Serialises the snapshot into a framed, checksummed byte packet over a valid/ready byte interface that feeds the UART transmitter.
- Handles frame decimation, send enable, and drop accounting when the link is still busy.

Parameters:
- DECIMATE, 1, send one packet every DECIMATE frame ends (1..255)
- SYNC0, 8'hAA, first header byte
- SYNC1, 8'h55, second header byte

Ports:
- CLK  in  1  system clock (pixel clock domain, same as the point finder)
- RESET_N  in  1  asynchronous active-low reset
- VGA_VS  in  1  vertical sync, high during active frame
- SEND_EN  in  1  level; 1 = packets allowed
- POINTS_H_0..POINTS_H_3  in  16 each  horizontal coordinate of points 0..3
- POINTS_V_0..POINTS_V_3  in  16 each  vertical coordinate of points 0..3
- TX_READY  in  1  downstream accepts byte
- TX_DATA  out  8  current packet byte
- TX_VALID  out  1  TX_DATA valid
- BUSY  out  1  packet in progress (state SEND)
- FRAME_CNT  out  8  number of packets started, wraps at 256
- DROP_CNT  out  8  frames lost because BUSY, saturates at 255

Behaviour:
- Reset (async, RESET_N=0):
  - TX_DATA=0, TX_VALID=0, BUSY=0, FRAME_CNT=0, DROP_CNT=0.
  - Decimation counter=0, vs_q=0, byte index=0, state=IDLE.
  - Reset mid-packet aborts the packet immediately; no completion after release.
- Frame end: vs_q registers VGA_VS. fe = vs_q & ~VGA_VS, a one-cycle pulse on the first clock VS is sampled low.
- Decimation counter dc:
  - On fe with SEND_EN=1: dc <= (dc==DECIMATE-1) ? 0 : dc+1.
  - A frame is eligible when fe & SEND_EN & dc==0.
  - While SEND_EN=0, dc is held at 0.
- State IDLE:
  - On an eligible frame, capture all 8 point inputs and the current FRAME_CNT value into the snapshot.
  - On the same edge: FRAME_CNT <= FRAME_CNT+1, TX_DATA <= SYNC0, TX_VALID <= 1, byte index <= 0, state <= SEND.
  - Latency: first byte is valid 1 cycle after the edge that samples fe.
- State SEND (20-byte packet). Byte order:
  - idx 0: SYNC0
  - idx 1: SYNC1
  - idx 2: snapshot FRAME_CNT
  - idx 3..18: H0[15:8], H0[7:0], V0[15:8], V0[7:0], H1.., V1.., H2.., V2.., H3.., V3..
  - idx 19: checksum = 8-bit modulo sum of bytes idx 2..18
- Handshake:
  - A byte transfers on an edge with TX_VALID & TX_READY; the next byte is presented on that same edge, so throughput is 1 byte/cycle with TX_READY tied high.
  - TX_DATA is held stable while TX_VALID=1 and TX_READY=0.
  - TX_VALID never drops mid-packet.
- Checksum accumulates as bytes are presented; it does not depend on TX_READY timing.
- Packet end: transfer of idx 19 sets TX_VALID <= 0 and state <= IDLE. An eligible frame on that exact edge is counted as a drop, not started.
- Eligible frame while BUSY=1: DROP_CNT increments (saturating at 255). Snapshot and packet are unchanged. Non-eligible frame ends never count as drops.
- SEND_EN falling mid-packet: the current packet completes normally.
- Live point inputs may change at any time; only the snapshot is transmitted.

Test Plan:
- Single packet: reset; SEND_EN=1, DECIMATE=1, TX_READY=1; points H0=0x0102 V0=0x0304 H1=0x0506 V1=0x0708 H2=0x090A V2=0x0B0C H3=0x0D0E V3=0x0F10; VS 1->0.
  - Expect 20 consecutive bytes AA 55 00 01 02 .. 0F 10 88.
  - Expect FRAME_CNT=1, BUSY low after the last byte.
- Backpressure: same stimulus, TX_READY toggles 1,0,0,1 repeating.
  - Expect identical byte sequence.
  - Expect TX_DATA unchanged during every stall cycle.
  - Expect no duplicated or skipped bytes.
- Snapshot integrity: change all POINTS inputs to 0xFFFF two cycles after the packet starts.
  - Expect the packet still carries the original values and checksum 0x88.
- Drop: TX_READY=0 holding a packet open, then 3 more VS falls.
  - Expect DROP_CNT=3 and FRAME_CNT=1.
  - After releasing TX_READY, expect exactly one packet.
- Decimation: DECIMATE=3, 7 VS falls spaced > 20 cycles apart.
  - Expect packets on falls 1, 4 and 7 only, with FRAME_CNT bytes 00, 01, 02.
  - Repeat with SEND_EN=0 and expect no packets.
- Reset mid-packet: assert RESET_N=0 at byte idx 10.
  - Expect TX_VALID=0 immediately and all counters 0.
  - After release, the next VS fall produces a full packet with frame byte 00.
